// File: rtl/alu_tile_driver.sv
// alu_tile_driver: sequences one ALU tile operation per command.
// Drives operands, waits a settle time, captures result, keeps CSR state.
module alu_tile_driver #(
  parameter int REG_WIDTH     = 32,
  parameter int CSR_IN_WIDTH  = 16,
  parameter int CSR_OUT_WIDTH = 16,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_op,
  input  logic [7:0]               cmd_a,
  input  logic [7:0]               cmd_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_result,
  output logic [3:0]               rsp_flags,
  output logic [3:0]               rsp_op,
  output logic [REG_WIDTH-1:0]     data_reg_a,
  output logic [REG_WIDTH-1:0]     data_reg_b,
  input  logic [REG_WIDTH-1:0]     data_reg_c,
  output logic [CSR_IN_WIDTH-1:0]  csr_in,
  input  logic [CSR_OUT_WIDTH-1:0] csr_out,
  input  logic                     csr_out_we,
  input  logic                     csr_in_re,
  output logic [15:0]              tile_status,
  output logic                     csr_rd_seen,
  output logic [15:0]              op_count,
  output logic [15:0]              err_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  settle_cnt;
  logic [7:0]  seq_id;
  logic        accept;
  logic        capture;
  logic        rsp_done;
  logic        err_hit;
  logic        busy;
  logic [15:0] csr_word;
  logic        unused_tile;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign capture   = (state == WAIT) && (settle_cnt == 4'd0);
  assign rsp_done  = (state == RESP) && rsp_valid && rsp_ready;
  assign err_hit   = |data_reg_c[31:29];
  assign busy      = (state != IDLE);
  assign csr_word  = {seq_id, 7'd0, busy};
  assign csr_in    = CSR_IN_WIDTH'(csr_word);

  // Middle tile bits carry nothing this driver consumes.
  assign unused_tile = ^data_reg_c[27:8];

  // Main sequencing: accept, settle, respond.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= WAIT;
        WAIT:    if (capture) state <= RESP;
        RESP:    if (rsp_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Settle countdown; parks at zero once capture fires.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      settle_cnt <= 4'd0;
    end else if (accept) begin
      settle_cnt <= SETTLE_INIT;
    end else if ((state == WAIT) && (settle_cnt != 4'd0)) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

  // Operand registers only move on accept.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      data_reg_a <= '0;
      data_reg_b <= '0;
    end else if (accept) begin
      data_reg_a <= REG_WIDTH'({cmd_op, 20'd0, cmd_a});
      data_reg_b <= REG_WIDTH'({24'd0, cmd_b});
    end
  end

  // Sequence id tags each accepted command, wrapping at 8 bits.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      seq_id <= 8'd0;
    end else if (accept) begin
      seq_id <= seq_id + 8'd1;
    end
  end

  // Read-seen flag: a read strobe beats a same-edge accept clear.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      csr_rd_seen <= 1'b0;
    end else if (csr_in_re) begin
      csr_rd_seen <= 1'b1;
    end else if (accept) begin
      csr_rd_seen <= 1'b0;
    end
  end

  // Response payload is captured once and held through RESP.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= 8'd0;
      rsp_flags  <= 4'd0;
      rsp_op     <= 4'd0;
    end else if (capture) begin
      rsp_valid  <= 1'b1;
      rsp_result <= data_reg_c[7:0];
      rsp_flags  <= data_reg_c[31:28];
      rsp_op     <= data_reg_a[31:28];
    end else if (rsp_done) begin
      rsp_valid  <= 1'b0;
    end
  end

  // Completion and error statistics; errors saturate.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      op_count  <= 16'd0;
      err_count <= 16'd0;
    end else if (capture) begin
      op_count <= op_count + 16'd1;
      if (err_hit && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

  // Tile status mirror, written whenever the tile strobes it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tile_status <= 16'd0;
    end else if (csr_out_we) begin
      tile_status <= 16'(csr_out);
    end
  end

endmodule

// File: tb/tb_alu_tile_driver.sv
// tb_alu_tile_driver: directed and random commands against a reference
// model of the command/response contract; a second copy uses settle 4.
`define CK(tag, o, e) chk(tag, 64'(o), 64'(e))

module tb_alu_tile_driver;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        rst_b = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd_op = '0;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic        rsp_ready = 1'b0;
  logic [31:0] data_reg_c = '0;
  logic [15:0] csr_out = '0;
  logic        csr_out_we = 1'b0;
  logic        csr_in_re = 1'b0;

  logic        cmd_ready, rsp_valid, csr_rd_seen;
  logic [7:0]  rsp_result;
  logic [3:0]  rsp_flags, rsp_op;
  logic [31:0] data_reg_a, data_reg_b;
  logic [15:0] csr_in, tile_status, op_count, err_count;

  logic        b_cmd_ready, b_rsp_valid, b_csr_rd_seen;
  logic [7:0]  b_rsp_result;
  logic [3:0]  b_rsp_flags, b_rsp_op;
  logic [31:0] b_data_reg_a, b_data_reg_b;
  logic [15:0] b_csr_in, b_tile_status, b_op_count, b_err_count;

  int n_chk = 0;
  int n_fail = 0;
  int exp_seq = 0;
  int exp_ops = 0;
  int exp_errs = 0;

  always #5 clk = ~clk;

  alu_tile_driver u0 (
    .clk(clk), .arst_n(arst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_op(rsp_op),
    .data_reg_a(data_reg_a), .data_reg_b(data_reg_b),
    .data_reg_c(data_reg_c), .csr_in(csr_in),
    .csr_out(csr_out), .csr_out_we(csr_out_we),
    .csr_in_re(csr_in_re), .tile_status(tile_status),
    .csr_rd_seen(csr_rd_seen), .op_count(op_count),
    .err_count(err_count)
  );

  alu_tile_driver #(.SETTLE_CYCLES(4)) u1 (
    .clk(clk), .arst_n(rst_b),
    .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(b_rsp_result), .rsp_flags(b_rsp_flags),
    .rsp_op(b_rsp_op),
    .data_reg_a(b_data_reg_a), .data_reg_b(b_data_reg_b),
    .data_reg_c(data_reg_c), .csr_in(b_csr_in),
    .csr_out(csr_out), .csr_out_we(csr_out_we),
    .csr_in_re(csr_in_re), .tile_status(b_tile_status),
    .csr_rd_seen(b_csr_rd_seen), .op_count(b_op_count),
    .err_count(b_err_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_u0(input string tag);
    `CK({tag, "_a"}, data_reg_a, 0);
    `CK({tag, "_b"}, data_reg_b, 0);
    `CK({tag, "_csr"}, csr_in, 0);
    `CK({tag, "_rv"}, rsp_valid, 0);
    `CK({tag, "_res"}, {rsp_result, rsp_flags, rsp_op}, 0);
    `CK({tag, "_ts"}, tile_status, 0);
    `CK({tag, "_rd"}, csr_rd_seen, 0);
    `CK({tag, "_cnt"}, {op_count, err_count}, 0);
    `CK({tag, "_rdy"}, cmd_ready, 1);
  endtask

  task automatic chk_zero_u1(input string tag);
    `CK({tag, "_a"}, b_data_reg_a, 0);
    `CK({tag, "_b"}, b_data_reg_b, 0);
    `CK({tag, "_csr"}, b_csr_in, 0);
    `CK({tag, "_rv"}, b_rsp_valid, 0);
    `CK({tag, "_res"}, {b_rsp_result, b_rsp_flags, b_rsp_op}, 0);
    `CK({tag, "_ts"}, b_tile_status, 0);
    `CK({tag, "_rd"}, b_csr_rd_seen, 0);
    `CK({tag, "_cnt"}, {b_op_count, b_err_count}, 0);
  endtask

  // One full command on u0, checked against the model counters.
  task automatic run_cmd(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [31:0] c,
                         input int hold, input bit re_acc,
                         input bit pulse_we, input logic [15:0] wv);
    logic [31:0] ea;
    ea = {op, 20'd0, a};
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    data_reg_c = c;
    csr_in_re = re_acc;
    `CK("ready_idle", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    csr_in_re = 1'b0;
    exp_seq = (exp_seq + 1) % 256;
    `CK("reg_a", data_reg_a, ea);
    `CK("reg_b", data_reg_b, {24'd0, b});
    `CK("busy", csr_in[0], 1);
    `CK("seq_id", csr_in[15:8], exp_seq);
    `CK("rd_seen_acc", csr_rd_seen, re_acc);
    `CK("no_rsp_yet", rsp_valid, 0);
    `CK("ready_wait", cmd_ready, 0);
    if (pulse_we) begin
      csr_out = wv;
      csr_out_we = 1'b1;
    end
    step();
    csr_out_we = 1'b0;
    if (pulse_we) `CK("tile_status", tile_status, wv);
    exp_ops++;
    if ((c[31:29] != 3'd0) && (exp_errs < 65535)) exp_errs++;
    `CK("rsp_valid", rsp_valid, 1);
    `CK("rsp_result", rsp_result, c[7:0]);
    `CK("rsp_flags", rsp_flags, c[31:28]);
    `CK("rsp_op", rsp_op, op);
    `CK("op_count", op_count, 16'(exp_ops));
    `CK("err_count", err_count, 16'(exp_errs));
    data_reg_c = $urandom();
    for (int i = 0; i < hold; i++) begin
      step();
      `CK("hold_valid", rsp_valid, 1);
      `CK("hold_result", rsp_result, c[7:0]);
      `CK("hold_flags", rsp_flags, c[31:28]);
      `CK("hold_op", rsp_op, op);
      `CK("hold_ready", cmd_ready, 0);
      `CK("hold_reg_a", data_reg_a, ea);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    `CK("rsp_drop", rsp_valid, 0);
    `CK("ready_back", cmd_ready, 1);
    `CK("busy_clr", csr_in[0], 0);
    `CK("reg_a_keep", data_reg_a, ea);
  endtask

  initial begin
    #2;
    chk_zero_u0("rst0");
    chk_zero_u1("rst1");
    step();
    step();
    arst_n = 1'b1;
    step();
    chk_zero_u0("post_rst");

    run_cmd(4'd0, 8'd200, 8'd100, 32'h4000002C, 0, 0, 0, 16'h0);
    run_cmd(4'd3, 8'd9, 8'd0, 32'h200000FF, 0, 0, 0, 16'h0);
    run_cmd(4'd2, 8'h5A, 8'hA5, 32'h00000013, 5, 0, 0, 16'h0);
    run_cmd(4'd1, 8'h11, 8'h22, 32'h10000000, 0, 0, 1, 16'hBEEF);

    csr_in_re = 1'b1;
    step();
    csr_in_re = 1'b0;
    `CK("rd_sticky0", csr_rd_seen, 1);
    step();
    step();
    `CK("rd_sticky1", csr_rd_seen, 1);
    run_cmd(4'd4, 8'h01, 8'h02, 32'h80000003, 1, 0, 0, 16'h0);
    run_cmd(4'd5, 8'h03, 8'h04, 32'h00000000, 0, 1, 0, 16'h0);
    run_cmd(4'd6, 8'h05, 8'h06, 32'hF00000AA, 2, 0, 1, 16'h1234);

    csr_out = 16'h5555;
    csr_out_we = 1'b1;
    step();
    csr_out_we = 1'b0;
    `CK("ts_idle", tile_status, 16'h5555);

    #2 arst_n = 1'b0;
    #1;
    chk_zero_u0("rst_mid");
    step();
    arst_n = 1'b1;
    exp_seq = 0;
    exp_ops = 0;
    exp_errs = 0;
    for (int k = 0; k < 256; k++) begin
      run_cmd(4'($urandom()), 8'($urandom()), 8'($urandom()),
              $urandom(), 0, 0, 0, 16'h0);
    end
    `CK("seq_wrap", csr_in[15:8], 8'h00);
    `CK("ops_256", op_count, 16'd256);

    rst_b = 1'b1;
    step();
    chk_zero_u1("u1_idle");
    cmd_valid = 1'b1;
    cmd_op = 4'd7;
    cmd_a = 8'h33;
    cmd_b = 8'h44;
    data_reg_c = 32'h7000001E;
    `CK("u1_ready", b_cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    `CK("u1_reg_a", b_data_reg_a, 32'h70000033);
    for (int i = 1; i <= 3; i++) begin
      step();
      `CK("u1_settling", b_rsp_valid, 0);
    end
    step();
    `CK("u1_rsp", b_rsp_valid, 1);
    `CK("u1_res", {b_rsp_flags, b_rsp_result, b_rsp_op}, 16'h71E7);
    `CK("u1_cnt", {b_op_count, b_err_count}, 32'h00010001);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    `CK("u1_done", b_cmd_ready, 1);

    cmd_valid = 1'b1;
    cmd_a = 8'h99;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    `CK("u1_wait", b_rsp_valid, 0);
    #2 rst_b = 1'b0;
    #1;
    chk_zero_u1("u1_abort");
    `CK("u1_abort_rdy", b_cmd_ready, 1);
    step();
    step();
    rst_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      `CK("u1_no_rsp", b_rsp_valid, 0);
      `CK("u1_no_cnt", b_op_count, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
